// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the single-port memory request master.
//   - state_t : master FSM states
//   - DEF_*   : default bus widths and memory depth
//   - req_t   : request bundle (write, addr, wdata) at default widths
//   - rsp_t   : response bundle (write, data, error) at default widths
package mem_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_MEM_DEPTH  = 16;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    READ_WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic                      write;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic                      write;
    logic [DEF_DATA_WIDTH-1:0] data;
    logic                      error;
  } rsp_t;

endpackage

// File: rtl/mem_req_master.sv
// mem_req_master: initiator for a single-port memory. Takes one read/write
// request at a time on a valid/ready stream, performs exactly one memory
// access, and returns one response on a valid/ready stream. Reads time out
// after TIMEOUT_CYCLES wait cycles; addresses >= MEM_DEPTH are rejected
// without touching the memory. All outputs are registered.
//
// Ports:
//   clk, rst                 clock (posedge), asynchronous active-low reset
//   req_valid/req_ready      request handshake
//   req_write/addr/wdata     request op, address, write data
//   rsp_valid/rsp_ready      response handshake
//   rsp_write/data/error     echoed op, read data (0 on write/error), error
//   WE, RE, Address, Data_in memory strobes, address and write data
//   Data_out, valid_out      memory read data and its valid
//   spurious_valid           sticky flag: valid_out seen outside READ_WAIT
module mem_req_master
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned MEM_DEPTH      = DEF_MEM_DEPTH,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_error,
  output logic                  WE,
  output logic                  RE,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] Data_in,
  input  logic [DATA_WIDTH-1:0] Data_out,
  input  logic                  valid_out,
  output logic                  spurious_valid
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept;
  logic             addr_illegal;

  assign accept       = req_valid && req_ready;
  assign addr_illegal = (32'(req_addr) >= 32'(MEM_DEPTH));

  // req_ready is a register rather than a decode of state so that it reads 0
  // throughout reset and rises on the first clock after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      req_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_write      <= 1'b0;
      rsp_data       <= '0;
      rsp_error      <= 1'b0;
      WE             <= 1'b0;
      RE             <= 1'b0;
      Address        <= '0;
      Data_in        <= '0;
      spurious_valid <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses; only the entering transition sets them.
      WE <= 1'b0;
      RE <= 1'b0;

      if (valid_out && (state != READ_WAIT)) begin
        spurious_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            if (addr_illegal) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_write <= req_write;
              rsp_data  <= '0;
              rsp_error <= 1'b1;
            end else if (req_write) begin
              state   <= WRITE;
              WE      <= 1'b1;
              Address <= req_addr;
              Data_in <= req_wdata;
            end else begin
              state   <= READ;
              RE      <= 1'b1;
              Address <= req_addr;
            end
          end
        end

        WRITE: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_write <= 1'b1;
          rsp_data  <= '0;
          rsp_error <= 1'b0;
        end

        READ: begin
          state    <= READ_WAIT;
          wait_cnt <= '0;
        end

        READ_WAIT: begin
          // Data arriving on the expiry cycle takes priority over the timeout.
          if (valid_out) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
            rsp_data  <= Data_out;
            rsp_error <= 1'b0;
          end else if (wait_cnt == CNT_LAST) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
            rsp_data  <= '0;
            rsp_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
